// File: rtl/pc_sequencer.sv
// Registered fetch-PC generator with J/JAL target resolution, a return-address
// stack for JR $31 prediction, and execute-stage redirect override.
`timescale 1ns/1ps
module pc_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter int          RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall,
    input  logic [31:0] instruction,
    input  logic        ex_redirect,
    input  logic [31:0] ex_target,
    output logic [31:0] fetch_pc,
    output logic        pc_misaligned,
    output logic        pred_ras_hit,
    output logic        ras_overflow,
    output logic        ras_underflow
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;

    logic [31:0]   pc_reg;
    logic [31:0]   ras_mem [RAS_DEPTH];
    logic [PW-1:0] ras_top;
    logic [CW-1:0] ras_count;
    logic          overflow_reg;
    logic          underflow_reg;

    logic [31:0]   seq;
    logic [31:0]   jump_target;
    logic [31:0]   next_pc;
    logic [PW-1:0] top_prev;
    logic          ras_empty;
    logic          ras_full;
    logic          is_j;
    logic          is_jal;
    logic          is_jr;
    logic          is_jalr;
    logic          rs_is_ra;
    logic          do_push;
    logic          do_pop;
    logic          set_underflow;
    logic          ras_hit;

    // ras_top is the next write slot; the most recent return address sits just below it.
    assign seq         = pc_reg + 32'd4;
    assign jump_target = {seq[31:28], instruction[25:0], 2'b00};
    assign top_prev    = ras_top - PW'(1);
    assign ras_empty   = (ras_count == '0);
    assign ras_full    = (ras_count == CW'(RAS_DEPTH));
    assign is_j        = (instruction[31:26] == OP_J);
    assign is_jal      = (instruction[31:26] == OP_JAL);
    assign is_jr       = (instruction[31:26] == OP_SPECIAL) && (instruction[5:0] == FN_JR);
    assign is_jalr     = (instruction[31:26] == OP_SPECIAL) && (instruction[5:0] == FN_JALR);
    assign rs_is_ra    = (instruction[25:21] == 5'd31);

    always_comb begin
        next_pc       = seq;
        do_push       = 1'b0;
        do_pop        = 1'b0;
        set_underflow = 1'b0;
        ras_hit       = 1'b0;
        if (ex_redirect) begin
            next_pc = ex_target;
        end else if (stall) begin
            next_pc = pc_reg;
        end else if (is_j || is_jal) begin
            next_pc = jump_target;
            do_push = is_jal;
        end else if (is_jr && rs_is_ra) begin
            if (!ras_empty) begin
                next_pc = ras_mem[top_prev];
                do_pop  = 1'b1;
                ras_hit = 1'b1;
            end else begin
                set_underflow = 1'b1;
            end
        end else if (is_jalr) begin
            do_push = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc_reg        <= RESET_PC;
            ras_top       <= '0;
            ras_count     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            pc_reg <= next_pc;
            // A push when full overwrites the oldest entry, which is the slot at ras_top.
            if (do_push) begin
                ras_top <= ras_top + PW'(1);
                if (ras_full) begin
                    overflow_reg <= 1'b1;
                end else begin
                    ras_count <= ras_count + CW'(1);
                end
            end else if (do_pop) begin
                ras_top   <= top_prev;
                ras_count <= ras_count - CW'(1);
            end
            if (set_underflow) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && do_push) begin
            ras_mem[ras_top] <= seq;
        end
    end

    assign fetch_pc      = pc_reg;
    assign pc_misaligned = |pc_reg[1:0];
    assign pred_ras_hit  = ras_hit;
    assign ras_overflow  = overflow_reg;
    assign ras_underflow = underflow_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: sequential fetch, J/JAL/JR/JALR,
// RAS overflow/underflow, redirect and stall priority, misalignment and mid-run reset.
`timescale 1ns/1ps
module tb_pc_sequencer;

    logic        clk;
    logic        resetn;
    logic        stall;
    logic [31:0] instruction;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic [31:0] fetch_pc;
    logic        pc_misaligned;
    logic        pred_ras_hit;
    logic        ras_overflow;
    logic        ras_underflow;

    int checkCount;
    int failCount;

    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] JR_RA  = 32'h03E0_0008;
    localparam logic [31:0] JR_R5  = 32'h00A0_0008;
    localparam logic [31:0] JALR_3 = 32'h0060_F809;
    localparam logic [31:0] BEQ    = 32'h1000_0004;

    pc_sequencer #(
        .RESET_PC (32'h0000_3000),
        .RAS_DEPTH(4)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .stall        (stall),
        .instruction  (instruction),
        .ex_redirect  (ex_redirect),
        .ex_target    (ex_target),
        .fetch_pc     (fetch_pc),
        .pc_misaligned(pc_misaligned),
        .pred_ras_hit (pred_ras_hit),
        .ras_overflow (ras_overflow),
        .ras_underflow(ras_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] jalTo(input logic [31:0] target);
        return {6'h03, target[27:2]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drives one cycle's inputs, checks the combinational RAS-hit flag, then clocks.
    task automatic applyStimulus(input logic [31:0] instr, input logic st, input logic red,
                                 input logic [31:0] tgt, input logic rn, input logic expHit);
        instruction = instr;
        stall       = st;
        ex_redirect = red;
        ex_target   = tgt;
        resetn      = rn;
        #1;
        checkOutput("pred_ras_hit", {31'd0, pred_ras_hit}, {31'd0, expHit});
        @(posedge clk);
        #1;
    endtask

    task automatic checkFlags(input string tag, input logic expOvf, input logic expUnf);
        checkOutput({tag, "_ovf"}, {31'd0, ras_overflow}, {31'd0, expOvf});
        checkOutput({tag, "_unf"}, {31'd0, ras_underflow}, {31'd0, expUnf});
    endtask

    logic [31:0] jalTargets [5];
    logic [31:0] returnPcs  [4];

    initial begin
        checkCount  = 0;
        failCount   = 0;
        resetn      = 1'b0;
        stall       = 1'b0;
        instruction = NOP;
        ex_redirect = 1'b0;
        ex_target   = 32'd0;

        // T1: reset held for two clocks
        applyStimulus(NOP, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        applyStimulus(NOP, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        checkOutput("reset_pc", fetch_pc, 32'h0000_3000);
        checkOutput("reset_misaligned", {31'd0, pc_misaligned}, 32'd0);
        checkOutput("reset_count", 32'(dut.ras_count), 32'd0);
        checkFlags("reset", 1'b0, 1'b0);

        // T2: sequential fetch then J 0x3040
        applyStimulus(NOP, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("seq_3004", fetch_pc, 32'h0000_3004);
        applyStimulus(NOP, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("seq_3008", fetch_pc, 32'h0000_3008);
        applyStimulus(32'h0800_0C10, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("j_3040", fetch_pc, 32'h0000_3040);

        // T3: J to 0x3010, JAL 0x3100, JR $31 back to 0x3014
        applyStimulus(32'h0800_0C04, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("j_3010", fetch_pc, 32'h0000_3010);
        applyStimulus(jalTo(32'h0000_3100), 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("jal_3100", fetch_pc, 32'h0000_3100);
        checkOutput("jal_count", 32'(dut.ras_count), 32'd1);
        applyStimulus(JR_RA, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        checkOutput("jr_ret_3014", fetch_pc, 32'h0000_3014);
        checkOutput("jr_count", 32'(dut.ras_count), 32'd0);

        // T4: five nested JALs overflow a depth-4 RAS
        jalTargets = '{32'h3200, 32'h3300, 32'h3400, 32'h3500, 32'h3600};
        returnPcs  = '{32'h3504, 32'h3404, 32'h3304, 32'h3204};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(jalTo(jalTargets[i]), 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
            checkOutput("nested_jal", fetch_pc, jalTargets[i]);
        end
        checkOutput("full_count", 32'(dut.ras_count), 32'd4);
        checkFlags("after_overflow", 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(JR_RA, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
            checkOutput("ras_return", fetch_pc, returnPcs[i]);
        end
        applyStimulus(JR_RA, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("underflow_seq", fetch_pc, 32'h0000_3208);
        checkFlags("after_underflow", 1'b1, 1'b1);

        // T5: redirect beats stall and JAL; stall holds the PC
        applyStimulus(jalTo(32'h0000_3700), 1'b1, 1'b1, 32'h0000_4000, 1'b1, 1'b0);
        checkOutput("redirect_pc", fetch_pc, 32'h0000_4000);
        checkOutput("redirect_count", 32'(dut.ras_count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(jalTo(32'h0000_3700), 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
            checkOutput("stall_hold", fetch_pc, 32'h0000_4000);
        end
        checkOutput("stall_count", 32'(dut.ras_count), 32'd0);
        applyStimulus(NOP, 1'b0, 1'b1, 32'h0000_4002, 1'b1, 1'b0);
        checkOutput("misaligned_pc", fetch_pc, 32'h0000_4002);
        checkOutput("misaligned_flag", {31'd0, pc_misaligned}, 32'd1);

        // T6: three pushes, then reset coincident with a JAL
        applyStimulus(NOP, 1'b0, 1'b1, 32'h0000_5000, 1'b1, 1'b0);
        applyStimulus(jalTo(32'h0000_5100), 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        applyStimulus(jalTo(32'h0000_5200), 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        applyStimulus(jalTo(32'h0000_5300), 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("pre_reset_pc", fetch_pc, 32'h0000_5300);
        checkOutput("pre_reset_count", 32'(dut.ras_count), 32'd3);
        applyStimulus(jalTo(32'h0000_5400), 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        checkOutput("midreset_pc", fetch_pc, 32'h0000_3000);
        checkOutput("midreset_count", 32'(dut.ras_count), 32'd0);
        checkFlags("midreset", 1'b0, 1'b0);
        applyStimulus(JR_RA, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("post_reset_jr", fetch_pc, 32'h0000_3004);
        checkFlags("post_reset_jr", 1'b0, 1'b1);

        // JR via a non-$31 register, JALR push, branch not-taken, then return to the JALR link
        applyStimulus(JR_R5, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("jr_r5_seq", fetch_pc, 32'h0000_3008);
        applyStimulus(JALR_3, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("jalr_seq", fetch_pc, 32'h0000_300C);
        checkOutput("jalr_count", 32'(dut.ras_count), 32'd1);
        applyStimulus(BEQ, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("branch_seq", fetch_pc, 32'h0000_3010);
        applyStimulus(JR_RA, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("stalled_jr_hold", fetch_pc, 32'h0000_3010);
        applyStimulus(JR_RA, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        checkOutput("jalr_return", fetch_pc, 32'h0000_300C);
        checkOutput("final_count", 32'(dut.ras_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
